// File: rtl/seq_mul16_cla.sv
// ============================================================================
// Module   : seq_mul16_cla (with CLA_16bit)
// Brief    : Sequential 16x16 unsigned shift-add multiplier, one CLA add/cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        gp,
  output logic        gg
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_c;
  logic [3:0]  w_grp_p;
  logic [3:0]  w_grp_g;
  logic [4:0]  w_grp_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_grp
      localparam int c_B = 4 * k;

      assign w_grp_p[k] = w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_p[c_B];
      assign w_grp_g[k] = w_g[c_B+3]
                        | (w_p[c_B+3] & w_g[c_B+2])
                        | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                        | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);

      // Intra-group lookahead from the group carry-in
      assign w_c[c_B]   = w_grp_c[k];
      assign w_c[c_B+1] = w_g[c_B] | (w_p[c_B] & w_grp_c[k]);
      assign w_c[c_B+2] = w_g[c_B+1] | (w_p[c_B+1] & w_g[c_B])
                        | (w_p[c_B+1] & w_p[c_B] & w_grp_c[k]);
      assign w_c[c_B+3] = w_g[c_B+2] | (w_p[c_B+2] & w_g[c_B+1])
                        | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                        | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_grp_c[k]);

      assign sum[c_B+3:c_B] = w_p[c_B+3:c_B] ^ w_c[c_B+3:c_B];
    end
  endgenerate

  // Second-level lookahead across the four groups
  assign w_grp_c[0] = cin;
  assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & cin);
  assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[1] & w_grp_p[0] & cin);
  assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);
  assign w_grp_c[4] = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & cin);

  assign cout = w_grp_c[4];
  assign gp   = &w_grp_p;
  assign gg   = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
              | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
              | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0]);

endmodule

module seq_mul16_cla #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  generate
    if (WIDTH != 16) begin : g_width_err
      $error("seq_mul16_cla: WIDTH must be 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mcand;
  logic [15:0] r_acc_hi;
  logic [15:0] r_acc_lo;
  logic [3:0]  r_cnt;

  logic [15:0] w_add_b;
  logic [15:0] w_sum;
  logic        w_cout;
  logic        w_unused_gp;
  logic        w_unused_gg;

  assign w_add_b = r_acc_lo[0] ? r_mcand : 16'h0000;

  CLA_16bit u_cla (
    .a    (r_acc_hi),
    .b    (w_add_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout),
    .gp   (w_unused_gp),
    .gg   (w_unused_gg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == 4'd15) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // 33-bit right shift of {carry, sum, acc_lo} keeps every add lossless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= 16'h0000;
      r_acc_hi <= 16'h0000;
      r_acc_lo <= 16'h0000;
      r_cnt    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= a;
            r_acc_hi <= 16'h0000;
            r_acc_lo <= b;
            r_cnt    <= 4'd0;
          end
        end
        S_RUN: begin
          r_acc_hi <= {w_cout, w_sum[15:1]};
          r_acc_lo <= {w_sum[0], r_acc_lo[15:1]};
          r_cnt    <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = {r_acc_hi, r_acc_lo};

endmodule

`default_nettype wire

// File: tb/tb_seq_mul16_cla.sv
// ============================================================================
// Module   : tb_seq_mul16_cla
// Brief    : Directed self-checking bench for seq_mul16_cla.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul16_cla;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks;
  int failures;

  seq_mul16_cla #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for out_valid with a bound, return latency.
  task automatic start_and_wait(input logic [15:0] va, input logic [15:0] vb,
                                input bit corrupt, output int lat, output bit early_acc);
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    early_acc = 1'b0;
    while (!out_valid && lat < 40) begin
      if (corrupt) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (in_ready) early_acc = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic [31:0] exp, input bit corrupt);
    int lat;
    bit early;
    start_and_wait(va, vb, corrupt, lat, early);
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_product"}, product, exp);
    check({tag, "_flags"}, {29'd0, in_ready, busy, out_valid}, 32'b011);
    if (corrupt) check({tag, "_no_reaccept"}, {31'd0, early}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_handshake"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    bit early;
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    check("reset_product", product, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_op("t1", 16'h1234, 16'h5678, 32'h06260060, 1'b0);
    run_op("t2", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    run_op("t3a", 16'h0000, 16'hABCD, 32'h00000000, 1'b0);
    run_op("t3b", 16'hABCD, 16'h0000, 32'h00000000, 1'b0);

    // Backpressure: product must hold while out_ready stays low
    out_ready = 1'b0;
    start_and_wait(16'h00FF, 16'h0100, 1'b0, lat, early);
    check("t4_latency", 32'(lat), 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold", {product[29:0], in_ready, out_valid}, {32'h0000FF00, 2'b01} & 32'hFFFFFFFF);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release", {30'd0, in_ready, out_valid}, 32'b10);

    run_op("t5", 16'h0003, 16'h0005, 32'h0000000F, 1'b1);

    // Reset abandoned mid-RUN
    @(negedge clk);
    a = 16'h7777; b = 16'h3333; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {29'd0, in_ready, busy, out_valid}, 32'b100);
    check("t6_reset_product", product, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op("t6", 16'h8000, 16'h0002, 32'h00010000, 1'b0);

    // out_ready high outside DONE must not disturb IDLE
    repeat (3) @(posedge clk);
    #1;
    check("idle_ignore_out_ready", {29'd0, in_ready, busy, out_valid}, 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
